// File: rtl/wb_mem_bist.sv
// Wishbone classic memory BIST master: writes an LFSR pattern over a word window,
// reads it back, and reports pass/fail, error count and the first failing word.
module wb_mem_bist #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned WORD_COUNT = 1024,
  parameter logic [31:0] SEED       = 32'h0000_0001,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] wb_rdata,
  output logic [3:0]        wb_sel,
  output logic              wb_we,
  output logic              wb_stb,
  output logic              wb_cyc,
  input  logic              wb_ack,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam logic [DATA_W-1:0] Poly    = 32'h8020_0003;
  localparam logic [DATA_W-1:0] SeedEff = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int unsigned IW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IdxLast = IW'(WORD_COUNT - 1);
  localparam logic [TW-1:0] ToLast  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StWr, StWrGap, StRd, StRdGap, StDone} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]  lfsr_q, lfsr_d, lfsr_next;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [15:0]        err_q, err_d;
  logic [ADDR_W-1:0]  fea_q, fea_d;
  logic [DATA_W-1:0]  fed_q, fed_d;
  logic               to_q, to_d;
  logic [ADDR_W-1:0]  addr;

  // Window wraps modulo 2^ADDR_W by plain truncation of the sum.
  assign addr      = ADDR_W'(START_ADDR) + ADDR_W'(idx_q);
  assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? Poly : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      lfsr_q  <= SeedEff;
      tcnt_q  <= '0;
      err_q   <= '0;
      fea_q   <= '0;
      fed_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
      fed_q   <= fed_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    fea_d   = fea_q;
    fed_d   = fed_q;
    to_d    = to_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWr;
          idx_d   = '0;
          lfsr_d  = SeedEff;
          tcnt_d  = '0;
          err_d   = '0;
          fea_d   = '0;
          fed_d   = '0;
          to_d    = 1'b0;
        end
      end
      StWr: begin
        if (wb_ack) begin
          lfsr_d  = lfsr_next;
          state_d = StWrGap;
        end else if (tcnt_q == ToLast) begin
          to_d    = 1'b1;
          state_d = StDone;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StWrGap: begin
        tcnt_d = '0;
        if (idx_q == IdxLast) begin
          idx_d   = '0;
          lfsr_d  = SeedEff;
          state_d = StRd;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = StWr;
        end
      end
      StRd: begin
        if (wb_ack) begin
          lfsr_d  = lfsr_next;
          state_d = StRdGap;
          if (wb_rdata != lfsr_q) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            // err_q only returns to zero on a new start, so zero means first error.
            if (err_q == 16'd0) begin
              fea_d = addr;
              fed_d = wb_rdata;
            end
          end
        end else if (tcnt_q == ToLast) begin
          to_d    = 1'b1;
          state_d = StDone;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StRdGap: begin
        tcnt_d = '0;
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = StRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_cyc         = (state_q == StWr) || (state_q == StRd);
    wb_stb         = wb_cyc;
    wb_we          = (state_q == StWr);
    wb_sel         = 4'hF;
    wb_addr        = wb_cyc ? addr : '0;
    wb_wdata       = wb_we ? lfsr_q : '0;
    busy           = (state_q == StWr) || (state_q == StWrGap) ||
                     (state_q == StRd) || (state_q == StRdGap);
    done           = (state_q == StDone);
    pass           = done && (err_q == 16'd0) && !to_q;
    fail           = done && !((err_q == 16'd0) && !to_q);
    timeout        = to_q;
    err_count      = err_q;
    first_err_addr = fea_q;
    first_err_data = fed_q;
  end

endmodule

// File: tb/tb_wb_mem_bist.sv
// Self-checking bench for wb_mem_bist: directed table, hand sequences and randomized runs
// against a pattern/error model computed from the LFSR definition.
module tb_wb_mem_bist;
  localparam int unsigned AW = 23;
  localparam int unsigned WC = 4;
  localparam int unsigned TO = 15;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam int unsigned WRAP_BASE = 32'h7F_FFFE;

  typedef logic [AW-1:0] addr_q_t[$];
  typedef logic [31:0]   data_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start_a = 1'b0, start_b = 1'b0;
  int checks = 0, errors = 0;

  // Instance A: window at 0, directed/random tests.
  logic [AW-1:0] a_addr, a_fea;
  logic [31:0] a_wdata, a_rdata, a_fed;
  logic [3:0] a_sel;
  logic a_we, a_stb, a_cyc, a_ack, a_busy, a_done, a_pass, a_fail, a_to;
  logic [15:0] a_errc;
  // Instance B: window wrapping the top of the address space, seed 0.
  logic [AW-1:0] b_addr, b_fea;
  logic [31:0] b_wdata, b_rdata, b_fed;
  logic [3:0] b_sel;
  logic b_we, b_stb, b_cyc, b_ack, b_busy, b_done, b_pass, b_fail, b_to;
  logic [15:0] b_errc;

  wb_mem_bist #(.ADDR_W(AW), .DATA_W(32), .START_ADDR(0), .WORD_COUNT(WC),
                .SEED(32'h1), .TIMEOUT(TO)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .wb_addr(a_addr), .wb_wdata(a_wdata),
    .wb_rdata(a_rdata), .wb_sel(a_sel), .wb_we(a_we), .wb_stb(a_stb), .wb_cyc(a_cyc),
    .wb_ack(a_ack), .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail),
    .timeout(a_to), .err_count(a_errc), .first_err_addr(a_fea), .first_err_data(a_fed)
  );

  wb_mem_bist #(.ADDR_W(AW), .DATA_W(32), .START_ADDR(WRAP_BASE), .WORD_COUNT(WC),
                .SEED(32'h0), .TIMEOUT(TO)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .wb_addr(b_addr), .wb_wdata(b_wdata),
    .wb_rdata(b_rdata), .wb_sel(b_sel), .wb_we(b_we), .wb_stb(b_stb), .wb_cyc(b_cyc),
    .wb_ack(b_ack), .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail),
    .timeout(b_to), .err_count(b_errc), .first_err_addr(b_fea), .first_err_data(b_fed)
  );

  // Slave A: ack in the a_lat-th cycle after stb rises; optional read corruption.
  int a_lat = 3;
  logic a_noack = 1'b0, a_force_ack = 1'b0, a_ack_r = 1'b0;
  logic [3:0] a_cmask = 4'h0;
  logic [3:0][31:0] a_cval = '0;
  logic [31:0] a_mem [4];
  int a_cnt = 0;
  addr_q_t a_wa;
  data_q_t a_wd;

  assign a_ack   = a_ack_r | a_force_ack;
  assign a_rdata = a_ack ? (a_cmask[a_addr[1:0]] ? a_cval[a_addr[1:0]] : a_mem[a_addr[1:0]])
                         : 32'h0;

  always @(posedge clk) begin
    if (a_cyc && a_stb && a_ack_r && a_we) begin
      a_mem[a_addr[1:0]] <= a_wdata;
      a_wa.push_back(a_addr);
      a_wd.push_back(a_wdata);
    end
    if (a_cyc && a_stb && !a_ack_r && !a_noack) begin
      if (a_cnt >= a_lat - 1) begin
        a_ack_r <= 1'b1;
        a_cnt   <= 0;
      end else begin
        a_cnt <= a_cnt + 1;
      end
    end else begin
      a_ack_r <= 1'b0;
      a_cnt   <= 0;
    end
  end

  // Slave B: ideal memory, fixed latency 2.
  logic b_ack_r = 1'b0;
  logic [31:0] b_mem [4];
  int b_cnt = 0;
  addr_q_t b_wa;
  data_q_t b_wd;

  assign b_ack   = b_ack_r;
  assign b_rdata = b_ack ? b_mem[b_addr[1:0]] : 32'h0;

  always @(posedge clk) begin
    if (b_cyc && b_stb && b_ack_r && b_we) begin
      b_mem[b_addr[1:0]] <= b_wdata;
      b_wa.push_back(b_addr);
      b_wd.push_back(b_wdata);
    end
    if (b_cyc && b_stb && !b_ack_r) begin
      if (b_cnt >= 1) begin
        b_ack_r <= 1'b1;
        b_cnt   <= 0;
      end else begin
        b_cnt <= b_cnt + 1;
      end
    end else begin
      b_ack_r <= 1'b0;
      b_cnt   <= 0;
    end
  end

  // Word i of the pattern: seed (0 -> 1) stepped i times through the Galois LFSR.
  function automatic logic [31:0] pat(input logic [31:0] seed, input int i);
    logic [31:0] s;
    s = (seed == 32'h0) ? 32'h1 : seed;
    for (int k = 0; k < i; k++) s = (s >> 1) ^ (s[0] ? POLY : 32'h0);
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_writes(input string tag, input addr_q_t wa, input data_q_t wd,
                            input int unsigned base, input logic [31:0] seed);
    chk($sformatf("%s_nwrites", tag), 64'(wa.size()), 64'(WC));
    for (int i = 0; i < int'(WC) && i < wa.size(); i++) begin
      chk($sformatf("%s_wr%0d_addr", tag, i), 64'(wa[i]), 64'((base + i) % (1 << AW)));
      chk($sformatf("%s_wr%0d_data", tag, i), 64'(wd[i]), 64'(pat(seed, i)));
    end
  endtask

  task automatic pulse_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n;
    n = 0;
    while (!a_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_reached"}, 64'(a_done), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int               lat;
    logic [3:0]       cmask;
    logic [3:0][31:0] cval;
    logic             exp_pass;
    logic             exp_to;
    logic [15:0]      exp_errc;
    logic [AW-1:0]    exp_fea;
    logic [31:0]      exp_fed;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n, e;
    logic [AW-1:0] fa;
    logic [31:0] fd;

    vecs[0] = '{3,  4'b0000, 128'h0, 1'b1, 1'b0, 16'd0, 23'd0, 32'h0};
    vecs[1] = '{3,  4'b0100, {32'h0, 32'hFFFF_FFFF, 64'h0}, 1'b0, 1'b0, 16'd1, 23'd2,
                32'hFFFF_FFFF};
    vecs[2] = '{1,  4'b1010, {32'h1234_5678, 96'h0}, 1'b0, 1'b0, 16'd2, 23'd1, 32'h0};
    vecs[3] = '{14, 4'b0000, 128'h0, 1'b1, 1'b0, 16'd0, 23'd0, 32'h0};
    vecs[4] = '{15, 4'b0000, 128'h0, 1'b0, 1'b1, 16'd0, 23'd0, 32'h0};
    vecs[5] = '{2,  4'b0001, {96'h0, 32'h0000_0001}, 1'b1, 1'b0, 16'd0, 23'd0, 32'h0};

    repeat (3) @(negedge clk);
    chk("rst_cyc", 64'(a_cyc), 64'd0);
    chk("rst_stb", 64'(a_stb), 64'd0);
    chk("rst_we", 64'(a_we), 64'd0);
    chk("rst_sel", 64'(a_sel), 64'hF);
    chk("rst_addr_wdata", {9'h0, a_addr, a_wdata}, 64'd0);
    chk("rst_flags", {a_busy, a_done, a_pass, a_fail, a_to}, 64'd0);
    chk("rst_results", {a_errc, a_fea, a_fed}, 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      a_lat = vecs[v].lat;
      a_cmask = vecs[v].cmask;
      a_cval = vecs[v].cval;
      a_wa.delete();
      a_wd.delete();
      pulse_a();
      wait_done_a($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_busy", v), 64'(a_busy), 64'd0);
      chk($sformatf("vec%0d_pass", v), 64'(a_pass), 64'(vecs[v].exp_pass));
      chk($sformatf("vec%0d_fail", v), 64'(a_fail), 64'(!vecs[v].exp_pass));
      chk($sformatf("vec%0d_timeout", v), 64'(a_to), 64'(vecs[v].exp_to));
      chk($sformatf("vec%0d_errc", v), 64'(a_errc), 64'(vecs[v].exp_errc));
      chk($sformatf("vec%0d_fea", v), 64'(a_fea), 64'(vecs[v].exp_fea));
      chk($sformatf("vec%0d_fed", v), 64'(a_fed), 64'(vecs[v].exp_fed));
      if (!vecs[v].exp_to) chk_writes($sformatf("vec%0d", v), a_wa, a_wd, 0, 32'h1);
    end

    // Slave never acks: cyc/stb held exactly TO cycles, then timeout.
    a_noack = 1'b1;
    a_cmask = '0;
    pulse_a();
    n = 0;
    while (a_cyc && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("noack_cyc_cycles", 64'(n), 64'(TO));
    chk("noack_flags", {a_cyc, a_stb, a_done, a_to, a_fail, a_pass}, 64'b001110);
    // Ack with stb low while in DONE must change nothing.
    a_force_ack = 1'b1;
    @(negedge clk);
    a_force_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_state", {a_busy, a_done, a_to, a_fail, a_cyc}, 64'b01110);
    chk("stray_ack_errc", 64'(a_errc), 64'd0);
    a_noack = 1'b0;

    // Wrap-around window on instance B, seed 0 behaves as seed 1.
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!b_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_done", 64'(b_done), 64'd1);
    chk("wrap_pass", {b_pass, b_fail, b_to, b_errc}, {45'h0, 3'b100, 16'h0});
    chk_writes("wrap", b_wa, b_wd, WRAP_BASE, 32'h0);

    // Reset during the read pass clears everything on the next edge.
    a_lat = 3;
    a_cmask = 4'b0001;
    a_cval = {96'h0, 32'hA5A5_A5A5};
    pulse_a();
    n = 0;
    while (a_errc == 16'd0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_pre_errc", 64'(a_errc), 64'd1);
    chk("rstmid_pre_fed", 64'(a_fed), 64'hA5A5_A5A5);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_flags", {a_cyc, a_stb, a_busy, a_done}, 64'd0);
    chk("rstmid_results", {a_errc, a_fea, a_fed}, 64'd0);
    rst = 1'b0;
    a_cmask = '0;
    a_wa.delete();
    a_wd.delete();
    pulse_a();
    wait_done_a("rstmid_rerun");
    chk("rstmid_rerun_pass", {a_pass, a_errc}, {47'h0, 1'b1, 16'h0});
    chk_writes("rstmid_rerun", a_wa, a_wd, 0, 32'h1);

    // Start while busy is ignored; start in DONE clears and reruns from index 0.
    a_cmask = 4'b0100;
    a_cval = {32'h0, 32'hFFFF_FFFF, 64'h0};
    a_wa.delete();
    a_wd.delete();
    pulse_a();
    n = 0;
    while (a_wa.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    pulse_a();
    wait_done_a("busy_start");
    chk_writes("busy_start", a_wa, a_wd, 0, 32'h1);
    chk("busy_start_result", {a_fail, a_errc, a_fed}, {15'h0, 1'b1, 16'd1, 32'hFFFF_FFFF});
    a_cmask = '0;
    a_wa.delete();
    a_wd.delete();
    pulse_a();
    chk("restart_cleared", {a_done, a_fail, a_busy, a_errc, a_fea}, {24'h0, 3'b001, 39'h0});
    chk("restart_first_beat", {a_cyc, a_we, a_addr, a_wdata}, {7'h0, 2'b11, 23'h0, 32'h1});
    wait_done_a("restart");
    chk("restart_pass", {a_pass, a_errc}, {47'h0, 1'b1, 16'h0});
    chk_writes("restart", a_wa, a_wd, 0, 32'h1);

    // Randomized latency and read corruption against the model.
    for (int r = 0; r < 20; r++) begin
      a_lat = $urandom_range(1, 8);
      a_cmask = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) a_cval[k] = ($urandom_range(0, 1) == 1) ? pat(32'h1, k) : $urandom;
      a_wa.delete();
      a_wd.delete();
      pulse_a();
      wait_done_a($sformatf("rnd%0d", r));
      e = 0;
      fa = '0;
      fd = '0;
      for (int i = 0; i < int'(WC); i++) begin
        if (a_cmask[i] && a_cval[i] != pat(32'h1, i)) begin
          if (e == 0) begin
            fa = AW'(i);
            fd = a_cval[i];
          end
          e++;
        end
      end
      chk($sformatf("rnd%0d_errc", r), 64'(a_errc), 64'(e));
      chk($sformatf("rnd%0d_first", r), {9'h0, a_fea, a_fed}, {9'h0, fa, fd});
      chk($sformatf("rnd%0d_flags", r), {a_pass, a_fail, a_to}, {e == 0, e != 0, 1'b0});
      chk_writes($sformatf("rnd%0d", r), a_wa, a_wd, 0, 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
